// File: rtl/opcode_fetch_latch.sv
// rtl/opcode_fetch_latch.sv - opcode capture with BRK substitution for reset/NMI/IRQ sequences
module opcode_fetch_latch #(
  parameter logic [7:0] BRK_OPCODE = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       sync,
  input  logic       rdy,
  input  logic       nmi,
  input  logic       irq,
  input  logic       i_flag,
  output logic [7:0] insn,
  output logic       insn_valid,
  output logic [1:0] int_kind,
  output logic [7:0] vec_lo
);

  localparam logic [1:0] KIND_NONE  = 2'b00;
  localparam logic [1:0] KIND_IRQ   = 2'b01;
  localparam logic [1:0] KIND_NMI   = 2'b10;
  localparam logic [1:0] KIND_RESET = 2'b11;

  localparam logic [7:0] VEC_IRQ   = 8'hFE;
  localparam logic [7:0] VEC_NMI   = 8'hFA;
  localparam logic [7:0] VEC_RESET = 8'hFC;

  typedef enum logic {S_RESET, S_RUN} state_t;

  state_t     state, state_next;
  logic       nmi_d;
  logic       nmi_pend, nmi_pend_next;
  logic [7:0] insn_next;
  logic       valid_next;
  logic [1:0] kind_next;
  logic [7:0] vec_next;
  logic       edge_now;
  logic       fetch;

  // A falling NMI pin is only a request once; the delayed copy re-arms after nmi returns high.
  assign edge_now = nmi_d & ~nmi;
  assign fetch    = sync & rdy;

  // Next-state and next-output selection: defaults hold everything, an accepted fetch picks by priority.
  always_comb begin
    state_next    = state;
    insn_next     = insn;
    kind_next     = int_kind;
    vec_next      = vec_lo;
    valid_next    = 1'b0;
    nmi_pend_next = nmi_pend | edge_now;
    if (fetch) begin
      valid_next = 1'b1;
      if (state == S_RESET) begin
        // The reset sequence leaves any NMI edge pending for the following fetch.
        state_next = S_RUN;
        insn_next  = BRK_OPCODE;
        kind_next  = KIND_RESET;
        vec_next   = VEC_RESET;
      end else if (nmi_pend | edge_now) begin
        insn_next     = BRK_OPCODE;
        kind_next     = KIND_NMI;
        vec_next      = VEC_NMI;
        nmi_pend_next = 1'b0;
      end else if (~irq & ~i_flag) begin
        insn_next = BRK_OPCODE;
        kind_next = KIND_IRQ;
        vec_next  = VEC_IRQ;
      end else begin
        insn_next = data_in;
        kind_next = KIND_NONE;
        vec_next  = VEC_IRQ;
      end
    end
  end

  // State and output registers; reset discards any pending NMI and restarts the reset sequence.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_RESET;
      nmi_d      <= 1'b1;
      nmi_pend   <= 1'b0;
      insn       <= BRK_OPCODE;
      insn_valid <= 1'b0;
      int_kind   <= KIND_RESET;
      vec_lo     <= VEC_RESET;
    end else begin
      state      <= state_next;
      nmi_d      <= nmi;
      nmi_pend   <= nmi_pend_next;
      insn       <= insn_next;
      insn_valid <= valid_next;
      int_kind   <= kind_next;
      vec_lo     <= vec_next;
    end
  end

endmodule

// File: tb/tb_opcode_fetch_latch.sv
// tb/tb_opcode_fetch_latch.sv - scoreboard bench for opcode_fetch_latch
module tb_opcode_fetch_latch;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_in;
  logic       sync, rdy, nmi, irq, i_flag;
  logic [7:0] insn;
  logic       insn_valid;
  logic [1:0] int_kind;
  logic [7:0] vec_lo;

  int checks = 0;
  int fails  = 0;
  logic [17:0] exp_q[$];

  opcode_fetch_latch #(.BRK_OPCODE(8'h00)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .sync(sync), .rdy(rdy),
    .nmi(nmi), .irq(irq), .i_flag(i_flag), .insn(insn),
    .insn_valid(insn_valid), .int_kind(int_kind), .vec_lo(vec_lo)
  );

  always #5 clk = ~clk;

  // Monitor: every valid pulse pops one expected {insn, kind, vec} and compares.
  initial begin
    logic [17:0] e;
    forever begin
      @(negedge clk);
      if (!rst && insn_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_valid: got insn=%h kind=%b vec=%h, required no output", insn, int_kind, vec_lo);
        end else begin
          e = exp_q.pop_front();
          if ({insn, int_kind, vec_lo} !== e) begin
            fails++;
            $display("FAIL fetch_output: got insn=%h kind=%b vec=%h, required insn=%h kind=%b vec=%h",
                     insn, int_kind, vec_lo, e[17:10], e[9:8], e[7:0]);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // One accepted fetch; the expected output is queued before the capturing edge.
  task automatic fetch(input logic [7:0] d, input logic [7:0] ei, input logic [1:0] ek, input logic [7:0] ev);
    data_in = d; sync = 1'b1; rdy = 1'b1;
    exp_q.push_back({ei, ek, ev});
    @(posedge clk); #1;
    sync = 1'b0; data_in = 8'hFF;
    idle(1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_insn"},  {24'h0, insn}, 32'h00);
    check({tag, "_valid"}, {31'h0, insn_valid}, 32'h0);
    check({tag, "_kind"},  {30'h0, int_kind}, 32'h3);
    check({tag, "_vec"},   {24'h0, vec_lo}, 32'hFC);
  endtask

  initial begin
    rst = 1'b1; data_in = 8'h00; sync = 1'b0; rdy = 1'b1;
    nmi = 1'b1; irq = 1'b1; i_flag = 1'b1;
    idle(2);
    check_reset_outputs("reset");
    rst = 1'b0;
    idle(1);

    // T1: reset sequence, then normal opcode
    fetch(8'hA9, 8'h00, 2'b11, 8'hFC);
    fetch(8'hA9, 8'hA9, 2'b00, 8'hFE);

    // T2: NMI edge between fetches, held low gives only one request
    nmi = 1'b0;
    idle(1);
    fetch(8'hEA, 8'h00, 2'b10, 8'hFA);
    fetch(8'hEA, 8'hEA, 2'b00, 8'hFE);
    nmi = 1'b1;
    idle(1);

    // T3: masked IRQ, then unmasked IRQ
    irq = 1'b0;
    fetch(8'h18, 8'h18, 2'b00, 8'hFE);
    i_flag = 1'b0;
    fetch(8'h18, 8'h00, 2'b01, 8'hFE);

    // T4: NMI edge and IRQ at the same fetch, NMI wins then IRQ
    nmi = 1'b0;
    fetch(8'h58, 8'h00, 2'b10, 8'hFA);
    fetch(8'h58, 8'h00, 2'b01, 8'hFE);
    nmi = 1'b1; irq = 1'b1; i_flag = 1'b1;
    fetch(8'hC5, 8'hC5, 2'b00, 8'hFE);

    // T5: stall with an NMI edge inside it, retry when rdy rises
    sync = 1'b1; rdy = 1'b0; data_in = 8'h77; nmi = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_valid", {31'h0, insn_valid}, 32'h0);
      check("stall_insn",  {24'h0, insn}, 32'hC5);
      @(posedge clk); #1;
    end
    fetch(8'h77, 8'h00, 2'b10, 8'hFA);
    nmi = 1'b1;
    idle(1);

    // T6: pending NMI discarded by asynchronous reset mid-cycle
    nmi = 1'b0;
    idle(1);
    #2 rst = 1'b1;
    #1 check_reset_outputs("async_reset");
    nmi = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(1);
    fetch(8'h4C, 8'h00, 2'b11, 8'hFC);
    fetch(8'h4C, 8'h4C, 2'b00, 8'hFE);

    // NMI edge on the injected-reset fetch stays pending for the next fetch
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(1);
    nmi = 1'b0;
    fetch(8'h20, 8'h00, 2'b11, 8'hFC);
    fetch(8'h20, 8'h00, 2'b10, 8'hFA);
    fetch(8'h20, 8'h20, 2'b00, 8'hFE);
    nmi = 1'b1;

    // sync low: no capture even with an unmasked IRQ
    irq = 1'b0; i_flag = 1'b0; data_in = 8'h99;
    idle(2);
    check("nosync_insn", {24'h0, insn}, 32'h20);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1);
    check("scoreboard_drained", exp_q.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
